// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver and its outcome queue.
package branch_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;

  localparam logic PRED_TAKEN     = 1'b1;
  localparam logic PRED_NOT_TAKEN = 1'b0;

  typedef struct packed {
    logic pred;
  } branch_entry_t;

  function automatic logic is_mispredict(input branch_entry_t entry, input logic taken);
    return entry.pred != taken;
  endfunction

endpackage

// File: rtl/outcome_fifo.sv
// Prediction queue with a reserve pointer (slot claimed at fetch) ahead of the
// write pointer (slot filled when the prediction arrives), plus a full flush.
module outcome_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          reserve,
  input  logic          write,
  input  branch_entry_t wdata,
  input  logic          pop,
  output branch_entry_t rdata,
  output logic [PW-1:0] occupancy,
  output logic [PW-1:0] captured
);

  branch_entry_t mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rsv_ptr;

  // Pointers carry one extra bit so full and empty differ without a count register.
  assign occupancy = rsv_ptr - rd_ptr;
  assign captured  = wr_ptr - rd_ptr;
  assign rdata     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rsv_ptr <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rsv_ptr <= '0;
    end else begin
      if (reserve) rsv_ptr <= rsv_ptr + 1'b1;
      if (write)   wr_ptr  <= wr_ptr + 1'b1;
      if (pop)     rd_ptr  <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// Queues branch predictions in program order and resolves them against execute.
// Optional statistics counters: define BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  output logic             pred_request,
  input  logic             pred_in,
  output logic             pred_bit,
  input  logic             exec_valid,
  input  logic             exec_taken,
  output logic             exec_ready,
  output logic             upd_result,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic          pending;
  logic          accept;
  logic          resolve;
  logic          mis;
  branch_entry_t head;
  branch_entry_t cap_entry;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] captured;

  // Readiness depends on registered state only, so exec_valid never reaches fetch_ready.
  assign fetch_ready  = occupancy < PW'(DEPTH);
  assign pred_request = fetch_valid & fetch_ready;
  assign accept       = pred_request;
  assign exec_ready   = captured != '0;
  assign resolve      = exec_valid & exec_ready;
  assign mis          = resolve & is_mispredict(head, exec_taken);
  assign cap_entry    = '{pred: pred_in};

  outcome_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (mis),
    .reserve   (accept),
    .write     (pending),
    .wdata     (cap_entry),
    .pop       (resolve),
    .rdata     (head),
    .occupancy (occupancy),
    .captured  (captured)
  );

  // A mispredict also drops the capture owed to a fetch accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (mis) begin
      pending <= 1'b0;
    end else begin
      pending <= accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_bit <= 1'b0;
    end else if (pending) begin
      pred_bit <= pred_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_result <= 1'b0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_result <= resolve;
      upd_taken  <= resolve & exec_taken;
      mispredict <= mis;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_W-1:0] branch_q;
  logic [CNT_W-1:0] mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (resolve && branch_q != '1) branch_q  <= branch_q + 1'b1;
      if (mis && mispred_q != '1)    mispred_q <= mispred_q + 1'b1;
    end
  end

  assign branch_count  = branch_q;
  assign mispred_count = mispred_q;
`else
  assign branch_count  = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver; resolves are scoreboarded against update pulses.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        pred_request;
  logic        pred_in;
  logic        pred_bit;
  logic        exec_valid;
  logic        exec_taken;
  logic        exec_ready;
  logic        upd_result;
  logic        upd_taken;
  logic        mispredict;
  logic [15:0] branch_count;
  logic [15:0] mispred_count;

`ifdef BRANCH_RESOLVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic taken;
    logic mis;
  } exp_t;

  exp_t sb[$];
  logic mq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_resolver #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .pred_request  (pred_request),
    .pred_in       (pred_in),
    .pred_bit      (pred_bit),
    .exec_valid    (exec_valid),
    .exec_taken    (exec_taken),
    .exec_ready    (exec_ready),
    .upd_result    (upd_result),
    .upd_taken     (upd_taken),
    .mispredict    (mispredict),
    .branch_count  (branch_count),
    .mispred_count (mispred_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic drive(input logic fv, input logic pin, input logic ev, input logic et);
    fetch_valid = fv;
    pred_in     = pin;
    exec_valid  = ev;
    exec_taken  = et;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every update pulse must match the oldest expected resolve.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (upd_result) begin
        if (sb.size() == 0) begin
          chk("upd_unexpected", 32'(upd_result), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_upd_taken", 32'(upd_taken), 32'(e.taken));
          chk("sb_mispredict", 32'(mispredict), 32'(e.mis));
        end
      end else begin
        chk("sb_mispredict_idle", 32'(mispredict), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic h;
    logic pin;

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    chk("rst_upd_result", 32'(upd_result), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_exec_ready", 32'(exec_ready), 0);
    chk("rst_pred_bit", 32'(pred_bit), 0);
    chk("rst_fetch_ready", 32'(fetch_ready), 1);
    rst_n = 1'b1;
    tick();

    // Single correct taken branch
    drive(1, 0, 0, 0);
    #1 chk("t1_pred_request", 32'(pred_request), 1);
    tick();
    chk("t1_pending_not_ready", 32'(exec_ready), 0);
    drive(0, 1, 0, 0);
    tick();
    chk("t1_pred_bit", 32'(pred_bit), 1);
    chk("t1_exec_ready", 32'(exec_ready), 1);
    drive(0, 0, 1, 1);
    sb.push_back('{1'b1, 1'b0});
    tick();
    chk("t1_upd_result", 32'(upd_result), 1);
    chk("t1_exec_ready_after", 32'(exec_ready), 0);
    chk("t1_branch_count", 32'(branch_count), ecnt(1));
    drive(0, 0, 0, 0);
    tick();
    chk("t1_upd_clear", 32'(upd_result), 0);

    // Predict not-taken, resolve taken
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("t2_pred_bit", 32'(pred_bit), 0);
    drive(0, 0, 1, 1);
    sb.push_back('{1'b1, 1'b1});
    tick();
    chk("t2_mispredict", 32'(mispredict), 1);
    chk("t2_upd_taken", 32'(upd_taken), 1);
    chk("t2_mispred_count", 32'(mispred_count), ecnt(1));
    drive(0, 0, 0, 0);
    tick();
    chk("t2_mispredict_one_cycle", 32'(mispredict), 0);

    // Fill to DEPTH back-to-back, all predicted taken
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    chk("t3_ready_at_3", 32'(fetch_ready), 1);
    drive(1, 1, 0, 0); tick();
    chk("t3_full", 32'(fetch_ready), 0);
    drive(0, 1, 0, 0); tick();
    repeat (4) mq.push_back(1'b1);
    drive(1, 0, 1, 1);
    #1 chk("t3_full_no_request", 32'(pred_request), 0);
    sb.push_back('{1'b1, 1'b0});
    void'(mq.pop_front());
    tick();
    chk("t3_ready_after_resolve", 32'(fetch_ready), 1);

    // Streaming: fetch and correct resolve every cycle across pointer wrap
    for (int i = 0; i < 10; i++) begin
      pin = (i > 0) ? logic'((i - 1) % 2) : 1'b0;
      h = mq.pop_front();
      drive(1, pin, 1, h);
      sb.push_back('{h, 1'b0});
      if (i > 0) mq.push_back(pin);
      tick();
    end
    drive(0, 1, 0, 0);
    mq.push_back(1'b1);
    tick();
    chk("t3_stream_fetch_ready", 32'(fetch_ready), 1);
    chk("t3_stream_exec_ready", 32'(exec_ready), 1);
    chk("t3_stream_count", 32'(branch_count), ecnt(13));

    // Mispredict on the oldest of 3 while a 4th is accepted
    h = mq.pop_front();
    drive(1, 0, 1, ~h);
    sb.push_back('{~h, 1'b1});
    tick();
    mq.delete();
    chk("t4_flush_exec_ready", 32'(exec_ready), 0);
    chk("t4_flush_fetch_ready", 32'(fetch_ready), 1);
    drive(0, 1, 0, 0);
    tick();
    chk("t4_capture_discarded", 32'(exec_ready), 0);
    chk("t4_branch_count", 32'(branch_count), ecnt(14));
    chk("t4_mispred_count", 32'(mispred_count), ecnt(2));

    // Resolve attempts with an empty queue and with only a pending slot
    drive(0, 0, 1, 1); tick();
    chk("t5_empty_no_upd", 32'(upd_result), 0);
    drive(1, 0, 1, 1); tick();
    chk("t5_pending_no_ready", 32'(exec_ready), 0);
    drive(0, 1, 1, 1); tick();
    chk("t5_pending_no_upd", 32'(upd_result), 0);
    chk("t5_captured_ready", 32'(exec_ready), 1);
    drive(0, 0, 0, 0); tick();
    chk("t5_upd_still_low", 32'(upd_result), 0);
    chk("t5_branch_count", 32'(branch_count), ecnt(14));
    chk("t5_mispred_count", 32'(mispred_count), ecnt(2));

    // Async reset with entries queued and an update pulse in flight
    drive(1, 0, 0, 0); tick();
    drive(0, 1, 0, 0); tick();
    drive(1, 0, 1, 1); tick();
    chk("t6_upd_before_reset", 32'(upd_result), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_upd_result", 32'(upd_result), 0);
    chk("t6_rst_upd_taken", 32'(upd_taken), 0);
    chk("t6_rst_mispredict", 32'(mispredict), 0);
    chk("t6_rst_pred_bit", 32'(pred_bit), 0);
    chk("t6_rst_exec_ready", 32'(exec_ready), 0);
    chk("t6_rst_branch_count", 32'(branch_count), 0);
    drive(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_fetch_ready", 32'(fetch_ready), 1);
    chk("t6_post_exec_ready", 32'(exec_ready), 0);

    tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution-side partner of the 2-bit branch predictor. It accepts branches from fetch, requests a prediction for each, and queues those predictions in program order. When execute resolves the oldest branch it compares the actual direction with the queued prediction, drives the predictor's `result`/`taken` update, and raises a one-cycle `mispredict` that flushes all younger branches.

## Interface
- `DEPTH`, default 4: maximum outstanding branches, including a capture in flight; power of two, at least 2.
- `CNT_W`, default 16: width of the statistics counters.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch presents a new branch.
- `fetch_ready`  out  1  a queue slot is free.
- `pred_request`  out  1  to predictor `request`; equals `fetch_valid & fetch_ready` (combinational).
- `pred_in`  in  1  from predictor `prediction`; valid in the cycle after `pred_request`.
- `pred_bit`  out  1  registered copy of the captured prediction, for fetch steering.
- `exec_valid`  in  1  the oldest branch is resolved.
- `exec_taken`  in  1  actual direction of that branch.
- `exec_ready`  out  1  at least one captured entry is queued.
- `upd_result`  out  1  to predictor `result`; one-cycle pulse.
- `upd_taken`  out  1  to predictor `taken`.
- `mispredict`  out  1  one-cycle pulse requesting a fetch flush.
- `branch_count`  out  CNT_W  number of resolved branches.
- `mispred_count`  out  CNT_W  number of mispredicted branches.

## Operation
- Fetch is accepted in cycle T when `fetch_valid & fetch_ready`. `pred_request` is high in T, the slot is reserved, and `pending` is set.
- In T+1 `pred_in` is written to the tail entry and `pred_bit` updates at the end of T+1. `pending` then clears unless a new fetch is accepted in T+1.
- `occupancy` counts queued entries plus the pending slot. `fetch_ready` is `occupancy < DEPTH`.
- `exec_ready` is high when `captured > 0`; the pending slot does not count. `exec_valid` is ignored while `exec_ready` is low.
- On a resolve (`exec_valid & exec_ready`) in cycle R:
  - pop the head entry;
  - set `upd_result`=1 and `upd_taken`=`exec_taken` for R+1;
  - set `mispredict`=1 for R+1 if `exec_taken != head.pred`.
- Mispredict resolve in R clears the whole queue, including any pending capture in R+1 and any fetch accepted in R. That fetch's `pred_request` still reaches the predictor, which is harmless because the predictor does not update on a request.
- A correct resolve and a fetch in the same cycle both proceed; occupancy is unchanged.
- Full with a resolve in the same cycle: `fetch_ready` stays low in that cycle, because it is derived from state only.
- Reset values: all outputs 0, queue empty, `pending`=0. `fetch_ready`=1 after reset. Reset mid-operation discards every entry immediately.

## Timing
- Prediction capture latency: 1 cycle after accept.
- Update latency: `upd_*` and `mispredict` are registered and appear 1 cycle after the resolve. The predictor's counter therefore changes 2 edges after the resolve.
- Resolve throughput: 1 per cycle. Back-to-back fetches: 1 per cycle.
- No combinational path from `exec_valid` to `fetch_ready`.

## Configuration
- `BRANCH_RESOLVER_STATS_EN`:
  - Defined: `branch_count` increments on every resolve and `mispred_count` on every mispredict. Both saturate at all-ones and reset to 0.
  - Undefined: both ports are driven to constant 0 and no counter flops are built.

## Structure
- Package `branch_pkg`:
  - `branch_entry_t`, a struct holding `pred`;
  - `PRED_TAKEN`/`PRED_NOT_TAKEN` constants;
  - the default `DEPTH`.
- Sub-module `outcome_fifo`: synchronous FIFO with a `flush` input and a split reserve/write tail pointer. Pointers are `$clog2(DEPTH)+1` bits and wrap naturally.
- The top level holds the `pending` flag, compare logic, update registers and statistics.

## Test plan
- Reset, then fetch one branch with `pred_in`=1 in T+1, then resolve with `exec_taken`=1 → `upd_result`=1, `upd_taken`=1, `mispredict`=0 one cycle later; `branch_count`=1.
- Predict 0, resolve taken → `mispredict`=1 for exactly one cycle, `upd_taken`=1, `mispred_count`=1.
- Issue 4 fetches back-to-back with `DEPTH`=4 → `fetch_ready`=0 after the 4th; one correct resolve → `fetch_ready`=1 the next cycle. Check pointer wrap over 10 cycles of streaming.
- Queue 3 entries, first resolve mispredicts while a 4th is accepted that cycle → queue empties, `exec_ready`=0, the 4th capture is discarded.
- Drive `exec_valid`=1 with an empty queue and with only a pending entry → no `upd_result`, counters unchanged.
- Deassert `rst_n` with 2 entries queued and `upd_result` high → all outputs 0 asynchronously; after release `fetch_ready`=1 and `exec_ready`=0.
